// File: rtl/scene_sequencer.sv
// Frame-rate scene controller: counts vsync rises, walks four scenes through
// FADE_IN / SHOW / FADE_OUT and drives scene select, frame count and brightness.
module scene_sequencer #(
  parameter int SCENE_LEN0  = 300,
  parameter int SCENE_LEN1  = 300,
  parameter int SCENE_LEN2  = 300,
  parameter int SCENE_LEN3  = 300,
  parameter int FADE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       pause,
  input  logic       skip,
  output logic [1:0] scene_id,
  output logic [9:0] scene_frame,
  output logic [1:0] brightness,
  output logic [1:0] phase,
  output logic       frame_tick,
  output logic       scene_start
);

  typedef enum logic [1:0] {
    FADE_IN  = 2'd0,
    SHOW     = 2'd1,
    FADE_OUT = 2'd2
  } phase_t;

  // Last show_cnt value of a scene; a zero length behaves as one frame.
  function automatic logic [9:0] show_last(input int len);
    logic [9:0] l;
    l = 10'(len);
    return (l == 10'd0) ? 10'd0 : l - 10'd1;
  endfunction

  localparam logic [9:0] LAST0     = show_last(SCENE_LEN0);
  localparam logic [9:0] LAST1     = show_last(SCENE_LEN1);
  localparam logic [9:0] LAST2     = show_last(SCENE_LEN2);
  localparam logic [9:0] LAST3     = show_last(SCENE_LEN3);
  localparam logic [7:0] STEP_LAST = 8'(FADE_FRAMES - 1);

  phase_t     state;
  logic [7:0] step_cnt;
  logic [9:0] show_cnt;
  logic       skip_pending;
  logic       vsync_q;

  logic       tick;
  logic       skip_now;
  logic       step_done;
  logic       show_done;
  logic [9:0] cur_last;

  assign tick      = vsync & ~vsync_q;
  // A skip on the tick cycle itself must be seen by that tick.
  assign skip_now  = skip_pending | skip;
  assign step_done = (step_cnt == STEP_LAST);
  assign show_done = (show_cnt == cur_last);
  assign phase     = state;

  always_comb begin
    cur_last = LAST0;
    case (scene_id)
      2'd0: cur_last = LAST0;
      2'd1: cur_last = LAST1;
      2'd2: cur_last = LAST2;
      2'd3: cur_last = LAST3;
      default: cur_last = LAST0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FADE_IN;
      scene_id     <= 2'd0;
      scene_frame  <= 10'd0;
      brightness   <= 2'd0;
      frame_tick   <= 1'b0;
      scene_start  <= 1'b0;
      step_cnt     <= 8'd0;
      show_cnt     <= 10'd0;
      skip_pending <= 1'b0;
      vsync_q      <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      frame_tick  <= tick;
      scene_start <= 1'b0;
      if (tick && !pause) begin
        // Every unpaused tick consumes any pending skip, whatever the phase.
        skip_pending <= 1'b0;
        scene_frame  <= scene_frame + 10'd1;
        case (state)
          FADE_IN: begin
            if (skip_now) begin
              state    <= FADE_OUT;
              step_cnt <= 8'd0;
            end else if (step_done) begin
              step_cnt   <= 8'd0;
              brightness <= brightness + 2'd1;
              if (brightness == 2'd2) begin
                state    <= SHOW;
                show_cnt <= 10'd0;
              end
            end else begin
              step_cnt <= step_cnt + 8'd1;
            end
          end
          SHOW: begin
            if (skip_now || show_done) begin
              state    <= FADE_OUT;
              show_cnt <= 10'd0;
              step_cnt <= 8'd0;
            end else begin
              show_cnt <= show_cnt + 10'd1;
            end
          end
          FADE_OUT: begin
            if (step_done) begin
              step_cnt <= 8'd0;
              if (brightness < 2'd2) begin
                scene_id    <= scene_id + 2'd1;
                brightness  <= 2'd0;
                scene_frame <= 10'd0;
                state       <= FADE_IN;
                scene_start <= 1'b1;
              end else begin
                brightness <= brightness - 2'd1;
              end
            end else begin
              step_cnt <= step_cnt + 8'd1;
            end
          end
          default: state <= FADE_IN;
        endcase
      end else if (skip) begin
        skip_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scene_sequencer.sv
// Bench for scene_sequencer: a behavioural model feeds an expected queue per
// frame; each scenario task also checks hand-derived milestones inline.
module tb_scene_sequencer;

  localparam int FF = 2;
  localparam int L0 = 3;
  localparam int L1 = 1;
  localparam int L2 = 2;
  localparam int L3 = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vsync = 1'b0;
  logic pause = 1'b0;
  logic skip = 1'b0;
  logic def_rst_n = 1'b0;
  logic def_pause = 1'b0;
  logic def_skip = 1'b0;

  logic [1:0] scene_id, brightness, phase;
  logic [9:0] scene_frame;
  logic       frame_tick, scene_start;
  logic [1:0] d_scene_id, d_brightness, d_phase;
  logic [9:0] d_scene_frame;
  logic       d_frame_tick, d_scene_start;

  int checks = 0;
  int failures = 0;
  int tick_no = 0;
  logic [16:0] exp_q[$];

  int m_scene, m_frame, m_bright, m_phase, m_step, m_show;
  bit m_pend, m_start;

  always #5 clk = ~clk;

  scene_sequencer #(
    .SCENE_LEN0(L0), .SCENE_LEN1(L1), .SCENE_LEN2(L2), .SCENE_LEN3(L3),
    .FADE_FRAMES(FF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .pause(pause), .skip(skip),
    .scene_id(scene_id), .scene_frame(scene_frame), .brightness(brightness),
    .phase(phase), .frame_tick(frame_tick), .scene_start(scene_start)
  );

  scene_sequencer dut_def (
    .clk(clk), .rst_n(def_rst_n), .vsync(vsync), .pause(def_pause), .skip(def_skip),
    .scene_id(d_scene_id), .scene_frame(d_scene_frame), .brightness(d_brightness),
    .phase(d_phase), .frame_tick(d_frame_tick), .scene_start(d_scene_start)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic int m_last(input int s);
    int len;
    len = (s == 0) ? L0 : (s == 1) ? L1 : (s == 2) ? L2 : L3;
    return (len == 0) ? 0 : len - 1;
  endfunction

  function automatic logic [16:0] m_pack();
    return {2'(m_scene), 10'(m_frame), 2'(m_bright), 2'(m_phase), m_start};
  endfunction

  task automatic model_reset;
    m_scene = 0; m_frame = 0; m_bright = 0; m_phase = 0;
    m_step = 0; m_show = 0; m_pend = 0; m_start = 0;
  endtask

  task automatic model_tick(input bit p, input bit s);
    bit adv;
    adv = 0;
    m_pend = m_pend | s;
    m_start = 0;
    if (!p) begin
      case (m_phase)
        0: begin
          if (m_pend) begin
            m_phase = 2; m_step = 0;
          end else if (m_step == FF - 1) begin
            m_step = 0; m_bright++;
            if (m_bright == 3) begin m_phase = 1; m_show = 0; end
          end else m_step++;
        end
        1: begin
          if (m_pend || m_show == m_last(m_scene)) begin
            m_phase = 2; m_show = 0; m_step = 0;
          end else m_show++;
        end
        default: begin
          if (m_step == FF - 1) begin
            m_step = 0;
            if (m_bright <= 1) adv = 1; else m_bright--;
          end else m_step++;
        end
      endcase
      m_pend = 0;
      if (adv) begin
        m_scene = (m_scene + 1) % 4; m_bright = 0; m_frame = 0; m_phase = 0; m_start = 1;
      end else m_frame = (m_frame + 1) % 1024;
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0; vsync = 1'b0; pause = 1'b0; skip = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
    exp_q.delete();
    tick_no = 0;
  endtask

  // One frame: vsync low for a random gap, then a rise carrying pause/skip.
  task automatic frame(input bit p, input bit s);
    int low;
    int waited;
    logic [16:0] exp_v, obs_v;
    low = $urandom_range(1, 4);
    vsync = 1'b0;
    pause = p;
    repeat (low) begin
      @(negedge clk);
      checks++;
      if (frame_tick !== 1'b0 || scene_start !== 1'b0) begin
        failures++;
        $display("FAIL pulse_width after tick %0d: frame_tick=%b scene_start=%b, required 0 0",
                 tick_no, frame_tick, scene_start);
      end
    end
    vsync = 1'b1;
    skip = s;
    model_tick(p, s);
    exp_q.push_back(m_pack());
    tick_no++;
    @(negedge clk);
    skip = 1'b0;
    checks++;
    if (frame_tick !== 1'b1) begin
      failures++;
      $display("FAIL tick_latency tick %0d: frame_tick=%b one cycle after rise, required 1",
               tick_no, frame_tick);
      waited = 0;
      while (frame_tick !== 1'b1 && waited < 4) begin
        @(negedge clk);
        waited++;
      end
    end
    exp_v = exp_q.pop_front();
    obs_v = {scene_id, scene_frame, brightness, phase, scene_start};
    checks++;
    if (obs_v !== exp_v) begin
      failures++;
      $display("FAIL scoreboard tick %0d: got scene=%0d frame=%0d bright=%0d phase=%0d start=%b, required scene=%0d frame=%0d bright=%0d phase=%0d start=%b",
               tick_no, obs_v[16:15], obs_v[14:5], obs_v[4:3], obs_v[2:1], obs_v[0],
               exp_v[16:15], exp_v[14:5], exp_v[4:3], exp_v[2:1], exp_v[0]);
    end
  endtask

  task automatic pulse_skip;
    skip = 1'b1;
    m_pend = 1;
    @(negedge clk);
    skip = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({scene_id, scene_frame, brightness, phase, frame_tick, scene_start} !== 18'd0) begin
      failures++;
      $display("FAIL reset_values: scene=%0d frame=%0d bright=%0d phase=%0d tick=%b start=%b, required all 0",
               scene_id, scene_frame, brightness, phase, frame_tick, scene_start);
    end
    frame(0, 0);
    checks++;
    if (scene_frame !== 10'd1 || brightness !== 2'd0 || phase !== 2'd0) begin
      failures++;
      $display("FAIL first_tick: frame=%0d bright=%0d phase=%0d, required 1 0 0",
               scene_frame, brightness, phase);
    end
  endtask

  task automatic test_full_sequence;
    int adv_t[4];
    adv_t = '{15, 28, 42, 55};
    do_reset();
    for (int t = 1; t <= 56; t++) begin
      frame(0, 0);
      if (t == 2 || t == 4 || t == 6) begin
        checks++;
        if (brightness !== 2'(t / 2)) begin
          failures++;
          $display("FAIL fade_in_step tick %0d: brightness=%0d, required %0d", t, brightness, t / 2);
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (t == adv_t[k]) begin
          checks++;
          if (scene_start !== 1'b1 || scene_id !== 2'((k + 1) % 4)) begin
            failures++;
            $display("FAIL scene_advance tick %0d: start=%b scene=%0d, required 1 %0d",
                     t, scene_start, scene_id, (k + 1) % 4);
          end
        end
      end
      if (t == 48) begin
        checks++;
        if (phase !== 2'd1 || scene_id !== 2'd3) begin
          failures++;
          $display("FAIL scene3_show tick 48: phase=%0d scene=%0d, required 1 3", phase, scene_id);
        end
      end
      if (t == 49) begin
        checks++;
        if (phase !== 2'd2) begin
          failures++;
          $display("FAIL scene3_fade_out tick 49: phase=%0d, required 2", phase);
        end
      end
    end
  endtask

  task automatic test_pause;
    do_reset();
    repeat (7) frame(0, 0);
    for (int i = 0; i < 5; i++) begin
      frame(1, 0);
      checks++;
      if (scene_id !== 2'd0 || scene_frame !== 10'd7 || brightness !== 2'd3 || phase !== 2'd1) begin
        failures++;
        $display("FAIL pause_hold %0d: scene=%0d frame=%0d bright=%0d phase=%0d, required 0 7 3 1",
                 i, scene_id, scene_frame, brightness, phase);
      end
    end
    frame(0, 0);
    checks++;
    if (scene_frame !== 10'd8 || phase !== 2'd1) begin
      failures++;
      $display("FAIL pause_resume1: frame=%0d phase=%0d, required 8 1", scene_frame, phase);
    end
    frame(0, 0);
    checks++;
    if (scene_frame !== 10'd9 || phase !== 2'd2) begin
      failures++;
      $display("FAIL pause_resume2: frame=%0d phase=%0d, required 9 2", scene_frame, phase);
    end
  endtask

  task automatic test_skip;
    do_reset();
    repeat (2) frame(0, 0);
    pulse_skip();
    frame(0, 0);
    checks++;
    if (phase !== 2'd2 || brightness !== 2'd1) begin
      failures++;
      $display("FAIL skip_fade_in: phase=%0d bright=%0d, required 2 1", phase, brightness);
    end
    repeat (2) frame(0, 0);
    checks++;
    if (scene_id !== 2'd1 || scene_start !== 1'b1) begin
      failures++;
      $display("FAIL skip_advance: scene=%0d start=%b, required 1 1", scene_id, scene_start);
    end
    repeat (8) frame(0, 0);
    pulse_skip();
    repeat (4) frame(0, 0);
    checks++;
    if (scene_id !== 2'd1 || phase !== 2'd2) begin
      failures++;
      $display("FAIL skip_fade_out_hold: scene=%0d phase=%0d, required 1 2", scene_id, phase);
    end
    frame(0, 0);
    checks++;
    if (scene_id !== 2'd2 || scene_start !== 1'b1) begin
      failures++;
      $display("FAIL skip_fade_out_advance: scene=%0d start=%b, required 2 1", scene_id, scene_start);
    end
    frame(1, 1);
    frame(1, 0);
    checks++;
    if (phase !== 2'd0) begin
      failures++;
      $display("FAIL skip_paused: phase=%0d, required 0", phase);
    end
    frame(0, 0);
    checks++;
    if (phase !== 2'd2 || scene_id !== 2'd2) begin
      failures++;
      $display("FAIL skip_after_pause: phase=%0d scene=%0d, required 2 2", phase, scene_id);
    end
  endtask

  task automatic test_long_vsync;
    int n;
    logic [16:0] exp_v, obs_v;
    n = 0;
    vsync = 1'b0;
    pause = 1'b0;
    repeat (2) @(negedge clk);
    vsync = 1'b1;
    model_tick(0, 0);
    exp_q.push_back(m_pack());
    tick_no++;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        n++;
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          obs_v = {scene_id, scene_frame, brightness, phase, scene_start};
          checks++;
          if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL long_vsync_value: got %h, required %h", obs_v, exp_v);
          end
        end
      end
    end
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL long_vsync_ticks: %0d frame_tick pulses, required 1", n);
    end
  endtask

  task automatic test_default_duration;
    int first_start;
    first_start = 0;
    vsync = 1'b0;
    @(negedge clk);
    def_rst_n = 1'b0;
    @(negedge clk);
    def_rst_n = 1'b1;
    for (int t = 1; t <= 326; t++) begin
      frame(0, 0);
      if (d_scene_start === 1'b1 && first_start == 0) first_start = t;
    end
    checks++;
    if (first_start != 324) begin
      failures++;
      $display("FAIL default_duration: first scene_start on tick %0d, required 324", first_start);
    end
    checks++;
    if (d_scene_id !== 2'd1) begin
      failures++;
      $display("FAIL default_scene: scene=%0d, required 1", d_scene_id);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    repeat (35) frame(0, 0);
    checks++;
    if (scene_id !== 2'd2 || phase !== 2'd1) begin
      failures++;
      $display("FAIL pre_reset_state: scene=%0d phase=%0d, required 2 1", scene_id, phase);
    end
    #2;
    rst_n = 1'b0;
    vsync = 1'b0;
    #1;
    checks++;
    if ({scene_id, scene_frame, brightness, phase, frame_tick, scene_start} !== 18'd0) begin
      failures++;
      $display("FAIL async_reset: scene=%0d frame=%0d bright=%0d phase=%0d, required all 0",
               scene_id, scene_frame, brightness, phase);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    tick_no = 0;
    for (int t = 1; t <= 15; t++) begin
      frame(0, 0);
      if (t == 2) begin
        checks++;
        if (brightness !== 2'd1) begin
          failures++;
          $display("FAIL restart_bright tick 2: brightness=%0d, required 1", brightness);
        end
      end
    end
    checks++;
    if (scene_id !== 2'd1 || scene_start !== 1'b1) begin
      failures++;
      $display("FAIL restart_advance tick 15: scene=%0d start=%b, required 1 1", scene_id, scene_start);
    end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_pause();
    test_skip();
    test_long_vsync();
    test_default_duration();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
